// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, HI/LO registers, iterative divider
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_alusel,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq
);

  // aluop encodings
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOR   = 8'h04;
  localparam logic [7:0] OP_SLL   = 8'h05;
  localparam logic [7:0] OP_SRL   = 8'h06;
  localparam logic [7:0] OP_SRA   = 8'h07;
  localparam logic [7:0] OP_ADD   = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_SLT   = 8'h0A;
  localparam logic [7:0] OP_SLTU  = 8'h0B;
  localparam logic [7:0] OP_MULT  = 8'h0C;
  localparam logic [7:0] OP_MULTU = 8'h0D;
  localparam logic [7:0] OP_DIV   = 8'h0E;
  localparam logic [7:0] OP_DIVU  = 8'h0F;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h11;
  localparam logic [7:0] OP_MTHI  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;

  // Divider states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int              CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  // Architectural and divider state
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      quo_q, quo_d;   // dividend magnitude shifting out, quotient shifting in
  logic [31:0]      rem_q, rem_d;   // partial remainder
  logic [31:0]      den_q, den_d;   // divisor magnitude
  logic             qneg_q, qneg_d; // negate quotient at the end
  logic             rneg_q, rneg_d; // negate remainder at the end

  // Combinational helpers
  logic [31:0] alu_res;
  logic        alu_wr;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_div;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        stall_c;

  // Operand conditioning shared by the multiplier and divider
  always_comb begin
    prod_u     = {32'b0, ex_reg1} * {32'b0, ex_reg2};
    prod_s     = {{32{ex_reg1[31]}}, ex_reg1} * {{32{ex_reg2[31]}}, ex_reg2};
    is_div     = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
    div_signed = (ex_aluop == OP_DIV);
    a_neg      = div_signed && ex_reg1[31];
    b_neg      = div_signed && ex_reg2[31];
    a_mag      = a_neg ? (32'd0 - ex_reg1) : ex_reg1;
    b_mag      = b_neg ? (32'd0 - ex_reg2) : ex_reg2;
    // One restoring step: shift the next dividend bit into the remainder and try subtracting
    rem_shift  = {rem_q, quo_q[31]};
    rem_diff   = rem_shift - {1'b0, den_q};
  end

  // Single-cycle ALU result and GPR write qualification
  always_comb begin
    alu_res = 32'd0;
    alu_wr  = 1'b0;
    case (ex_aluop)
      OP_AND:  begin alu_res = ex_reg1 & ex_reg2;    alu_wr = 1'b1; end
      OP_OR:   begin alu_res = ex_reg1 | ex_reg2;    alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = ex_reg1 ^ ex_reg2;    alu_wr = 1'b1; end
      OP_NOR:  begin alu_res = ~(ex_reg1 | ex_reg2); alu_wr = 1'b1; end
      OP_SLL:  begin alu_res = ex_reg2 << ex_reg1[4:0]; alu_wr = 1'b1; end
      OP_SRL:  begin alu_res = ex_reg2 >> ex_reg1[4:0]; alu_wr = 1'b1; end
      OP_SRA:  begin alu_res = $signed(ex_reg2) >>> ex_reg1[4:0]; alu_wr = 1'b1; end
      OP_ADD:  begin alu_res = ex_reg1 + ex_reg2; alu_wr = 1'b1; end
      OP_SUB:  begin alu_res = ex_reg1 - ex_reg2; alu_wr = 1'b1; end
      OP_SLT:  begin alu_res = {31'd0, ($signed(ex_reg1) < $signed(ex_reg2))}; alu_wr = 1'b1; end
      OP_SLTU: begin alu_res = {31'd0, (ex_reg1 < ex_reg2)}; alu_wr = 1'b1; end
      OP_MFHI: begin alu_res = hi_q; alu_wr = 1'b1; end
      OP_MFLO: begin alu_res = lo_q; alu_wr = 1'b1; end
      default: begin alu_res = 32'd0; alu_wr = 1'b0; end
    endcase
  end

  // Write-back bundle; forced to zero while reset is asserted
  always_comb begin
    wd_o     = rst ? ex_wd : 5'd0;
    wreg_o   = rst && ex_wreg && (ex_alusel != 3'd0) && alu_wr;
    wdata_o  = (rst && (ex_alusel != 3'd0)) ? alu_res : 32'd0;
    stallreq = rst && stall_c;
  end

  // Divider FSM and HI/LO next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          stall_c = 1'b1;
          if (ex_reg2 != 32'd0) begin
            quo_d   = a_mag;
            rem_d   = 32'd0;
            den_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            // Divide by zero skips the iteration and commits a fixed result in DONE
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = ex_reg1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          case (ex_aluop)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MTHI:  hi_d = ex_reg1;
            OP_MTLO:  lo_d = ex_reg1;
            default:  ;
          endcase
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (!rem_diff[32]) begin
          rem_d = rem_diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Apply signs: quotient by sign mismatch, remainder follows the dividend
        hi_d    = rneg_q ? (32'd0 - rem_q) : rem_q;
        lo_d    = qneg_q ? (32'd0 - quo_q) : quo_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any divide in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      den_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOR   = 8'h04;
  localparam logic [7:0] OP_SLL   = 8'h05;
  localparam logic [7:0] OP_SRL   = 8'h06;
  localparam logic [7:0] OP_SRA   = 8'h07;
  localparam logic [7:0] OP_ADD   = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_SLT   = 8'h0A;
  localparam logic [7:0] OP_SLTU  = 8'h0B;
  localparam logic [7:0] OP_MULT  = 8'h0C;
  localparam logic [7:0] OP_MULTU = 8'h0D;
  localparam logic [7:0] OP_DIV   = 8'h0E;
  localparam logic [7:0] OP_DIVU  = 8'h0F;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h11;
  localparam logic [7:0] OP_MTHI  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;

  typedef struct packed {
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  wd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq)
  );

  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return b << a[4:0];
      OP_SRL:  return b >> a[4:0];
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // Drive a bundle one cycle and record what the write-back bundle must be
  task automatic put(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] wd, input logic wr,
                     input logic [31:0] ew, input logic ewr);
    exp_t e;
    @(posedge clk); #1;
    ex_aluop  = op;
    ex_alusel = sel;
    ex_reg1   = a;
    ex_reg2   = b;
    ex_wd     = wd;
    ex_wreg   = wr;
    e.wdata = ew;
    e.wreg  = ewr;
    e.wd    = wd;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b0;
    ex_aluop = OP_ADD; ex_alusel = 3'd1; ex_reg1 = 32'd1; ex_reg2 = 32'd2; ex_wd = 5'd3; ex_wreg = 1'b1;
    @(negedge clk);
    checks++;
    if ({wdata_o, wreg_o, wd_o, stallreq} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wdata=%h wreg=%b wd=%0d stall=%b, want all zero", wdata_o, wreg_o, wd_o, stallreq);
    end
    ex_aluop = OP_DIV; ex_reg2 = 32'd7;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got stallreq=%b, want 0", stallreq);
    end
    ex_aluop = OP_NOP;
    @(posedge clk); #1;
    rst = 1'b1;
    put(OP_MFHI, 3'd1, 32'd0, 32'd0, 5'd2, 1'b1, 32'd0, 1'b1);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL reset_mfhi: got wdata=%h wreg=%b, want wdata=%h wreg=%b", wdata_o, wreg_o, e.wdata, e.wreg);
    end
    put(OP_MFLO, 3'd1, 32'd0, 32'd0, 5'd2, 1'b1, 32'd0, 1'b1);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL reset_mflo: got wdata=%h wreg=%b, want wdata=%h wreg=%b", wdata_o, wreg_o, e.wdata, e.wreg);
    end
  endtask

  task automatic test_alu;
    exp_t e;
    logic [7:0]  t_op  [9] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_NOP, 8'h20, OP_ADD, OP_OR};
    logic [2:0]  t_sel [9] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd1};
    logic [31:0] t_a   [9] = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'h5, 32'h5, 32'h1, 32'hF0F0_0000};
    logic [31:0] t_b   [9] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h8000_0000, 32'h6, 32'h6, 32'h1, 32'h0000_0F0F};
    logic [31:0] t_w   [9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hF800_0000, 32'h0, 32'h0, 32'h0, 32'hF0F0_0F0F};
    logic        t_wr  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  r_op  [8] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_ADD, OP_SUB};
    for (int i = 0; i < 9; i++) begin
      put(t_op[i], t_sel[i], t_a[i], t_b[i], 5'(i + 1), 1'b1, t_w[i], t_wr[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({wdata_o, wreg_o, wd_o} !== e) begin
        errors++;
        $display("FAIL alu_table[%0d] op=%h: got wdata=%h wreg=%b wd=%0d, want wdata=%h wreg=%b wd=%0d",
                 i, t_op[i], wdata_o, wreg_o, wd_o, e.wdata, e.wreg, e.wd);
      end
    end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  op;
      a  = $urandom;
      b  = $urandom;
      op = r_op[i % 8];
      put(op, 3'd2, a, b, 5'(i + 10), 1'b1, ref_alu(op, a, b), 1'b1);
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({wdata_o, wreg_o, wd_o} !== e) begin
        errors++;
        $display("FAIL alu_rand op=%h a=%h b=%h: got wdata=%h wreg=%b, want wdata=%h wreg=%b",
                 op, a, b, wdata_o, wreg_o, e.wdata, e.wreg);
      end
    end
  endtask

  task automatic test_mult;
    exp_t e;
    logic [7:0]  t_op [6] = '{OP_MULT, OP_MFHI, OP_MFLO, OP_MULTU, OP_MFHI, OP_MFLO};
    logic [31:0] t_w  [6] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h1, 32'hFFFF_FFFE};
    logic        t_wr [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      put(t_op[i], t_wr[i] ? 3'd1 : 3'd0, 32'hFFFF_FFFF, 32'h2, 5'd7, t_wr[i], t_w[i], t_wr[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({wdata_o, wreg_o, wd_o} !== e || stallreq !== 1'b0) begin
        errors++;
        $display("FAIL mult[%0d] op=%h: got wdata=%h wreg=%b stall=%b, want wdata=%h wreg=%b stall=0",
                 i, t_op[i], wdata_o, wreg_o, stallreq, e.wdata, e.wreg);
      end
    end
  endtask

  task automatic test_divide(input string name, input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int exp_cycles,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit disturb);
    exp_t e;
    int n;
    put(op, 3'd0, a, b, 5'd0, 1'b0, 32'd0, 1'b0);
    n = 0;
    @(negedge clk);
    while (stallreq === 1'b1 && n < 100) begin
      n++;
      if (disturb && n == 10) begin
        ex_reg1 = ~ex_reg1;
        ex_reg2 = 32'd3;
      end
      @(negedge clk);
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d, want %0d", name, n, exp_cycles);
    end
    e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL %s_done_bundle: got wdata=%h wreg=%b, want wdata=%h wreg=%b", name, wdata_o, wreg_o, e.wdata, e.wreg);
    end
    put(OP_MFHI, 3'd1, 32'd0, 32'd0, 5'd4, 1'b1, exp_hi, 1'b1);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL %s_hi: got %h, want %h", name, wdata_o, e.wdata);
    end
    put(OP_MFLO, 3'd1, 32'd0, 32'd0, 5'd4, 1'b1, exp_lo, 1'b1);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL %s_lo: got %h, want %h", name, wdata_o, e.wdata);
    end
  endtask

  task automatic test_reset_mid_div;
    exp_t e;
    put(OP_MTHI, 3'd0, 32'hAA, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL rst_div_mthi: got wdata=%h wreg=%b, want wdata=%h wreg=%b", wdata_o, wreg_o, e.wdata, e.wreg);
    end
    put(OP_DIVU, 3'd0, 32'd100, 32'd7, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL rst_div_bundle: got wdata=%h wreg=%b, want wdata=%h wreg=%b", wdata_o, wreg_o, e.wdata, e.wreg);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (stallreq !== 1'b1) begin
      errors++;
      $display("FAIL rst_div_busy: got stallreq=%b, want 1", stallreq);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_div_drop: got stallreq=%b, want 0", stallreq);
    end
    ex_aluop = OP_NOP;
    @(posedge clk); #1;
    rst = 1'b1;
    put(OP_MFHI, 3'd1, 32'd0, 32'd0, 5'd9, 1'b1, 32'd0, 1'b1);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_div_hi: got %h stall=%b, want %h stall=0", wdata_o, stallreq, e.wdata);
    end
    put(OP_MFLO, 3'd1, 32'd0, 32'd0, 5'd9, 1'b1, 32'd0, 1'b1);
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({wdata_o, wreg_o, wd_o} !== e) begin
      errors++;
      $display("FAIL rst_div_lo: got %h, want %h", wdata_o, e.wdata);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [7:0]  t_op [4] = '{OP_MTHI, OP_MFHI, OP_MTLO, OP_MFLO};
    logic [31:0] t_w  [4] = '{32'h0, 32'h1234, 32'h0, 32'h55};
    logic [31:0] t_a  [4] = '{32'h1234, 32'h0, 32'h55, 32'h0};
    logic        t_wr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      put(t_op[i], 3'd1, t_a[i], 32'd0, 5'd12, 1'b1, t_w[i], t_wr[i]);
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({wdata_o, wreg_o, wd_o} !== e) begin
        errors++;
        $display("FAIL b2b[%0d] op=%h: got wdata=%h wreg=%b, want wdata=%h wreg=%b",
                 i, t_op[i], wdata_o, wreg_o, e.wdata, e.wreg);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_mult;
    test_divide("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    test_divide("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    test_divide("div_by_zero", OP_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b0);
    test_divide("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b1);
    test_divide("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 33, 32'hF, 32'h0FFF_FFFF, 1'b1);
    test_reset_mid_div;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
